// File: rtl/rr_stream_arbiter.sv
// Round-robin merge of NUM_REQ valid/ready streams into one, tagging each beat with its source index.
// Latency 1 cycle through a single output register; a new beat loads in the cycle the old one drains.
// Backpressure: no req_ready while the output is full and down_ready is low. Define ARB_LOCK_EN for burst locking.
module rr_stream_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  localparam int SRC_W  = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
`ifdef ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]        req_last,
`endif
  output logic [DATA_W-1:0]         down_data,
  output logic                      down_valid,
  input  logic                      down_ready,
  output logic [SRC_W-1:0]          down_src
);

  logic [SRC_W-1:0]  rr_ptr;
  logic [SRC_W-1:0]  gnt;
  logic [SRC_W-1:0]  gnt_nxt;
  logic              gnt_vld;
  logic              out_free;
  logic              up_xfer;
  logic [DATA_W-1:0] sel_data;
`ifdef ARB_LOCK_EN
  logic              locked;
  logic [SRC_W-1:0]  lock_src;
`endif

  // Modulo-NUM_REQ add; correct for non-power-of-two NUM_REQ since base < NUM_REQ.
  function automatic logic [SRC_W-1:0] wrap_add(input logic [SRC_W-1:0] base, input logic [31:0] ofs);
    logic [31:0] sum;
    sum = 32'(base) + ofs;
    if (sum >= 32'(NUM_REQ)) sum = sum - 32'(NUM_REQ);
    return sum[SRC_W-1:0];
  endfunction

  // Walk from the farthest offset down so the nearest valid requester to rr_ptr wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[wrap_add(rr_ptr, 32'(k))]) begin
        gnt_vld = 1'b1;
        gnt     = wrap_add(rr_ptr, 32'(k));
      end
    end
`ifdef ARB_LOCK_EN
    if (locked) begin
      gnt_vld = req_valid[lock_src];
      gnt     = lock_src;
    end
`endif
  end

  assign gnt_nxt  = wrap_add(gnt, 32'd1);
  assign out_free = !down_valid || down_ready;
  assign up_xfer  = gnt_vld && out_free && !rst;
  assign sel_data = req_data[int'(gnt)*DATA_W +: DATA_W];

  always_comb begin
    req_ready = '0;
    if (up_xfer) req_ready[gnt] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      down_valid <= 1'b0;
      down_data  <= '0;
      down_src   <= '0;
      rr_ptr     <= '0;
`ifdef ARB_LOCK_EN
      locked     <= 1'b0;
      lock_src   <= '0;
`endif
    end else if (up_xfer) begin
      down_valid <= 1'b1;
      down_data  <= sel_data;
      down_src   <= gnt;
`ifdef ARB_LOCK_EN
      // Pointer stays put for the whole burst and moves past the owner only on its last beat.
      if (req_last[gnt]) begin
        locked <= 1'b0;
        rr_ptr <= gnt_nxt;
      end else begin
        locked   <= 1'b1;
        lock_src <= gnt;
      end
`else
      rr_ptr     <= gnt_nxt;
`endif
    end else if (down_ready) begin
      down_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Bench for rr_stream_arbiter: directed steps plus a randomized phase, all compared against a queue-free spec model.
module tb_rr_stream_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
`ifdef ARB_LOCK_EN
  logic [N-1:0]   req_last;
`endif
  logic [W-1:0]   down_data;
  logic           down_valid;
  logic           down_ready;
  logic [SW-1:0]  down_src;

  always #5 clk = ~clk;

  rr_stream_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_data   (req_data),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
`ifdef ARB_LOCK_EN
    .req_last   (req_last),
`endif
    .down_data  (down_data),
    .down_valid (down_valid),
    .down_ready (down_ready),
    .down_src   (down_src)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         m_ptr;
  int         m_src;
  int         m_lsrc;
  int         m_g;
  bit         m_vld;
  bit         m_locked;
  logic [W-1:0] m_data;
  bit         acc;
  int         acc_cnt [N];
  bit         dlv;
  int         dlv_src;
  logic [W-1:0] dlv_dat;

  function automatic int model_grant();
    if (rst) return -1;
    if (m_locked) return req_valid[m_lsrc] ? m_lsrc : -1;
    for (int k = 0; k < N; k++)
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: compare at negedge, advance model at posedge, return 1 time unit later.
  task automatic cycle();
    int g;
    bit free;
    logic [N-1:0] one;
    logic [N-1:0] exp_rdy;
    one = 1;
    @(negedge clk);
    g    = model_grant();
    free = !m_vld || down_ready;
    exp_rdy = (g >= 0 && free) ? (one << g) : '0;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("down_valid", 32'(down_valid), 32'(m_vld));
    chk("down_data", 32'(down_data), 32'(m_data));
    chk("down_src", 32'(down_src), 32'(m_src));
    dlv     = down_valid && down_ready;
    dlv_src = int'(down_src);
    dlv_dat = down_data;
    @(posedge clk);
    acc = 1'b0;
    if (rst) begin
      m_vld = 0; m_data = '0; m_src = 0; m_ptr = 0; m_locked = 0; m_lsrc = 0;
    end else if (g >= 0 && free) begin
      acc = 1'b1;
      m_g = g;
      acc_cnt[g]++;
      m_vld  = 1;
      m_data = req_data[g*W +: W];
      m_src  = g;
`ifdef ARB_LOCK_EN
      if (req_last[g]) begin
        m_locked = 0;
        m_ptr    = (g + 1) % N;
      end else begin
        m_locked = 1;
        m_lsrc   = g;
      end
`else
      m_ptr = (g + 1) % N;
`endif
    end else if (down_ready) begin
      m_vld = 0;
    end
    #1;
  endtask

  // Random upstream: a pending beat is held until accepted, otherwise a fresh beat may appear.
  task automatic drive_rand(input int pv, input int pr);
    for (int i = 0; i < N; i++) begin
      if (!req_valid[i] || (acc && m_g == i)) begin
        req_valid[i]         = ($urandom_range(99) < pv);
        req_data[i*W +: W]   = W'($urandom);
`ifdef ARB_LOCK_EN
        req_last[i]          = 1'($urandom);
`endif
      end
    end
    down_ready = ($urandom_range(99) < pr);
    rst        = ($urandom_range(59) == 0);
  endtask

  initial begin
    logic [W-1:0] exp2;
    int n_del;
    int a0;

    m_ptr = 0; m_src = 0; m_lsrc = 0; m_g = 0; m_vld = 0; m_locked = 0; m_data = '0;
    acc = 0; dlv = 0; dlv_src = 0; dlv_dat = '0;
    for (int i = 0; i < N; i++) acc_cnt[i] = 0;

    rst = 1'b1; req_valid = '1; req_data = '0; down_ready = 1'b1;
`ifdef ARB_LOCK_EN
    req_last = '1;
`endif
    repeat (2) @(posedge clk);
    #1;
    cycle();                         // reset held with all valid: no ready, outputs cleared
    rst = 1'b0; req_valid = '0;
    cycle();
    chk("idle_vld", 32'(down_valid), 32'd0);

    // All requesters valid: strict rotation 0,1,2,3,0,1 at one beat per cycle
    for (int i = 0; i < N; i++) req_data[i*W +: W] = W'(8'h10 + i);
    req_valid = '1;
    for (int j = 0; j < 6; j++) begin
      cycle();
      chk("rr_src", 32'(down_src), 32'(j % N));
      chk("rr_data", 32'(down_data), 32'(8'h10 + j % N));
      chk("rr_vld", 32'(down_valid), 32'd1);
    end

    // Single requester under toggling down_ready: each beat delivered once, in order
    req_valid = 4'b0100;
    req_data[2*W +: W] = 8'h20;
    exp2 = 8'h20; n_del = 0; a0 = acc_cnt[2];
    for (int j = 0; j < 19; j++) begin
      down_ready = (j < 16) ? (j % 2 == 0) : 1'b1;
      if (j == 16) req_valid = '0;
      cycle();
      if (dlv && dlv_src == 2) begin
        chk("order2", 32'(dlv_dat), 32'(exp2));
        exp2++;
        n_del++;
      end
      if (acc && m_g == 2) req_data[2*W +: W] = req_data[2*W +: W] + 1'b1;
    end
    chk("count2", 32'(n_del), 32'(acc_cnt[2] - a0));

    // Pointer wrap: grant 3, then 0, then 1
    down_ready = 1'b1;
    req_valid = 4'b1000;
    cycle();
    chk("wrap3", 32'(down_src), 32'd3);
    req_valid = 4'b0011;
    cycle();
    chk("wrap0", 32'(down_src), 32'd0);
    cycle();
    chk("wrap1", 32'(down_src), 32'd1);
    req_valid = '0;
    cycle();

    // Reset with a stalled beat in the output register
    req_valid = 4'b0010;
    cycle();
    req_valid = 4'b1010;
    down_ready = 1'b0;
    cycle();
    chk("stall_vld", 32'(down_valid), 32'd1);
    rst = 1'b1;
    cycle();
    chk("rst_vld", 32'(down_valid), 32'd0);
    rst = 1'b0;
    cycle();
    chk("rst_src", 32'(down_src), 32'd1);

`ifdef ARB_LOCK_EN
    // Burst from 1 is not interleaved with 0 and 2
    req_valid = '0; down_ready = 1'b1;
    repeat (2) cycle();
    req_valid = 4'b0001; req_last = '1;
    cycle();
    req_valid = 4'b0111; req_last = 4'b1101;
    cycle();
    chk("lock_b1", 32'(down_src), 32'd1);
    cycle();
    chk("lock_b2", 32'(down_src), 32'd1);
    req_last[1] = 1'b1;
    cycle();
    chk("lock_b3", 32'(down_src), 32'd1);
    cycle();
    chk("lock_rel2", 32'(down_src), 32'd2);
    cycle();
    chk("lock_rel0", 32'(down_src), 32'd0);
`endif

    // Randomized traffic with occasional resets
    for (int j = 0; j < 600; j++) begin
      drive_rand((j < 300) ? 90 : 40, (j < 300) ? 70 : 95);
      cycle();
    end
    rst = 1'b0;
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
